// File: rtl/seg7_scan_driver_if.sv
// CPU data-bus slice seen by the 7-segment scan driver: address, write data/strobe and the
// combinational read-back path.
interface seg7_scan_driver_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] dataIn;
   logic                  wrEnable;
   logic [DATA_WIDTH-1:0] dataOut;
   logic                  hit;

   modport master (
      output addr,
      output dataIn,
      output wrEnable,
      input  dataOut,
      input  hit
   );

   modport slave (
      input  addr,
      input  dataIn,
      input  wrEnable,
      output dataOut,
      output hit
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Memory-mapped DIGIT/CTRL registers driving a time-multiplexed 7-segment display, one digit
// per scan slot with a one-cycle blank between slots.
module seg7_scan_driver #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DIGITS     = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h100,
   parameter int unsigned           SCAN_DIV   = 1024
) (
   input  logic                clk,
   input  logic                rst,
   seg7_scan_driver_if.slave   bus,
   output logic [7:0]          led,
   output logic [DIGITS-1:0]   gate
);

   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DivW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

   logic [4*DIGITS-1:0] digit_q;
   logic                en_q;
   logic [7:0]          dp_q, blank_q;
   state_e              state_q, state_d;
   logic [DivW-1:0]     div_q, div_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [7:0]          led_q, led_d;
   logic [DIGITS-1:0]   gate_q, gate_d;

   logic                sel_digit, sel_ctrl;
   logic [31:0]         ctrl_rd;
   logic [3:0]          nib;
   logic                dp_bit, blank_bit;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      unique case (v)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign sel_digit = (bus.addr == BASE_ADDR);
   assign sel_ctrl  = (bus.addr == BASE_ADDR + ADDR_WIDTH'(4));
   assign ctrl_rd   = {en_q, 7'b0, dp_q, 8'b0, blank_q};

   always_comb begin
      bus.dataOut = '0;
      if (sel_digit) begin
         bus.dataOut = DATA_WIDTH'(digit_q);
      end else if (sel_ctrl) begin
         bus.dataOut = DATA_WIDTH'(ctrl_rd);
      end
   end

   assign bus.hit = sel_digit | sel_ctrl;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      idx_d   = idx_q;
      if (!en_q) begin
         state_d = StIdle;
         div_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StShow;
               div_d   = '0;
               idx_d   = '0;
            end
            StShow: begin
               if (div_q == DivW'(SCAN_DIV - 1)) begin
                  state_d = StBlank;
                  div_d   = '0;
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            StBlank: begin
               state_d = StShow;
               idx_d   = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end
            default: begin
               state_d = StIdle;
               div_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Output stage looks at the current (post-edge) state; it is registered one cycle later.
   always_comb begin
      nib       = '0;
      dp_bit    = 1'b0;
      blank_bit = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx_q == IdxW'(i)) begin
            nib       = digit_q[4*i +: 4];
            dp_bit    = dp_q[i];
            blank_bit = blank_q[i];
         end
      end
      led_d  = '0;
      gate_d = '0;
      if (en_q && (state_q == StShow) && !blank_bit) begin
         gate_d = DIGITS'(1) << idx_q;
         led_d  = {dp_bit, hex7(nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         digit_q <= '0;
         en_q    <= 1'b0;
         dp_q    <= '0;
         blank_q <= '0;
         state_q <= StIdle;
         div_q   <= '0;
         idx_q   <= '0;
         led_q   <= '0;
         gate_q  <= '0;
      end else begin
         if (bus.wrEnable && sel_digit) begin
            digit_q <= bus.dataIn[4*DIGITS-1:0];
         end
         if (bus.wrEnable && sel_ctrl) begin
            en_q    <= bus.dataIn[31];
            dp_q    <= bus.dataIn[23:16];
            blank_q <= bus.dataIn[7:0];
         end
         state_q <= state_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         led_q   <= led_d;
         gate_q  <= gate_d;
      end
   end

   assign led  = led_q;
   assign gate = gate_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: a 4-digit / SCAN_DIV=4 instance for scan behaviour and an 8-digit instance
// for full-width register read-back.
module tb_seg7_scan_driver;

   localparam logic [31:0] Base = 32'h0000_0100;

   logic       clk;
   logic       rst;
   logic [7:0] led4, led8;
   logic [3:0] gate4;
   logic [7:0] gate8;

   int n_cmp = 0;
   int n_err = 0;

   seg7_scan_driver_if bus4 ();
   seg7_scan_driver_if bus8 ();

   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut4 (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus4),
      .led  (led4),
      .gate (gate4)
   );

   seg7_scan_driver #(.DIGITS(8), .SCAN_DIV(4)) dut8 (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus8),
      .led  (led8),
      .gate (gate8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write4(input logic [31:0] a, input logic [31:0] d);
      bus4.addr = a; bus4.dataIn = d; bus4.wrEnable = 1'b1;
      tick();
      bus4.wrEnable = 1'b0; bus4.addr = '0; bus4.dataIn = '0;
   endtask

   task automatic write8(input logic [31:0] a, input logic [31:0] d);
      bus8.addr = a; bus8.dataIn = d; bus8.wrEnable = 1'b1;
      tick();
      bus8.wrEnable = 1'b0; bus8.addr = '0; bus8.dataIn = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus4.addr = Base + 32'(4 * (i % 2)); bus4.dataIn = $urandom; bus4.wrEnable = 1'b1;
         bus8.addr = Base + 32'(4 * (i % 2)); bus8.dataIn = $urandom; bus8.wrEnable = 1'b1;
         tick();
      end
      bus4.wrEnable = 1'b0; bus8.wrEnable = 1'b0;
      n_cmp++;
      if ({gate4, led4} !== 12'h000) begin
         n_err++; $display("FAIL reset_out: gate=%b led=%h, want 0000/00", gate4, led4);
      end
      bus4.addr = Base; #1;
      n_cmp++;
      if (bus4.dataOut !== 32'h0) begin
         n_err++; $display("FAIL reset_digit_rd: got %h want 00000000", bus4.dataOut);
      end
      bus4.addr = Base + 32'h4; #1;
      n_cmp++;
      if (bus4.dataOut !== 32'h0) begin
         n_err++; $display("FAIL reset_ctrl_rd: got %h want 00000000", bus4.dataOut);
      end
      bus4.addr = '0;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if ({gate4, led4} !== 12'h000 || {gate8, led8} !== 16'h0000) begin
            n_err++;
            $display("FAIL idle_out cyc %0d: gate4=%b led4=%h gate8=%b led8=%h, want all 0",
                     i, gate4, led4, gate8, led8);
         end
      end
   endtask

   task automatic test_scan_order();
      logic [7:0] exp_led [4] = '{8'h06, 8'h5B, 8'h4F, 8'h66};
      logic [3:0] eg;
      write4(Base, 32'h0000_4321);
      write4(Base + 32'h4, 32'h8000_0000);
      tick();
      n_cmp++;
      if ({gate4, led4} !== 12'h000) begin
         n_err++; $display("FAIL scan_lag: gate=%b led=%h, want 0000/00", gate4, led4);
      end
      tick();
      for (int s = 0; s < 4; s++) begin
         eg = 4'b0001 << s;
         for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (gate4 !== eg || led4 !== exp_led[s]) begin
               n_err++;
               $display("FAIL scan_show slot %0d cyc %0d: gate=%b led=%h, want %b/%h",
                        s, c, gate4, led4, eg, exp_led[s]);
            end
            tick();
         end
         n_cmp++;
         if ({gate4, led4} !== 12'h000) begin
            n_err++; $display("FAIL scan_blank slot %0d: gate=%b led=%h, want 0000/00", s, gate4, led4);
         end
         tick();
      end
      n_cmp++;
      if (gate4 !== 4'b0001 || led4 !== 8'h06) begin
         n_err++; $display("FAIL scan_wrap: gate=%b led=%h, want 0001/06", gate4, led4);
      end
   endtask

   task automatic test_masks();
      logic [3:0] eg [2] = '{4'b0001, 4'b0000};
      logic [7:0] el [2] = '{8'h86, 8'h00};
      write4(Base + 32'h4, 32'h0000_0000);
      write4(Base + 32'h4, 32'h8001_0002);
      tick(); tick();
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (gate4 !== eg[s] || led4 !== el[s]) begin
               n_err++;
               $display("FAIL mask_slot %0d cyc %0d: gate=%b led=%h, want %b/%h",
                        s, c, gate4, led4, eg[s], el[s]);
            end
            tick();
         end
         tick();
      end
      n_cmp++;
      if (gate4 !== 4'b0100 || led4 !== 8'h4F) begin
         n_err++; $display("FAIL mask_timing: gate=%b led=%h, want 0100/4F", gate4, led4);
      end
   endtask

   // Rewriting CTRL with enable kept high must continue the scan where it was.
   task automatic test_ctrl_rewrite();
      write4(Base + 32'h4, 32'h8000_0000);
      for (int c = 0; c < 3; c++) begin
         n_cmp++;
         if (gate4 !== 4'b0100 || led4 !== 8'h4F) begin
            n_err++; $display("FAIL rewrite_d2 cyc %0d: gate=%b led=%h, want 0100/4F", c, gate4, led4);
         end
         tick();
      end
      tick();
      n_cmp++;
      if (gate4 !== 4'b1000 || led4 !== 8'h66) begin
         n_err++; $display("FAIL rewrite_d3: gate=%b led=%h, want 1000/66", gate4, led4);
      end
      repeat (5) tick();
      n_cmp++;
      if (gate4 !== 4'b0001 || led4 !== 8'h06) begin
         n_err++; $display("FAIL rewrite_d0: gate=%b led=%h, want 0001/06", gate4, led4);
      end
   endtask

   task automatic test_disable();
      repeat (10) tick();
      n_cmp++;
      if (gate4 !== 4'b0100 || led4 !== 8'h4F) begin
         n_err++; $display("FAIL dis_pre: gate=%b led=%h, want 0100/4F", gate4, led4);
      end
      write4(Base + 32'h4, 32'h0000_0000);
      n_cmp++;
      if (gate4 !== 4'b0100) begin
         n_err++; $display("FAIL dis_edge_n: gate=%b, want 0100", gate4);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++;
         if ({gate4, led4} !== 12'h000) begin
            n_err++; $display("FAIL dis_off cyc %0d: gate=%b led=%h, want 0000/00", c, gate4, led4);
         end
      end
      write4(Base + 32'h4, 32'h8000_0000);
      tick(); tick();
      n_cmp++;
      if (gate4 !== 4'b0001 || led4 !== 8'h06) begin
         n_err++; $display("FAIL dis_restart: gate=%b led=%h, want 0001/06", gate4, led4);
      end
   endtask

   task automatic test_reset_mid();
      repeat (10) tick();
      n_cmp++;
      if (gate4 !== 4'b0100) begin
         n_err++; $display("FAIL rstmid_pre: gate=%b, want 0100", gate4);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_cmp++;
      if ({gate4, led4} !== 12'h000) begin
         n_err++; $display("FAIL rstmid_out: gate=%b led=%h, want 0000/00", gate4, led4);
      end
      bus4.addr = Base + 32'h4; #1;
      n_cmp++;
      if (bus4.dataOut !== 32'h0) begin
         n_err++; $display("FAIL rstmid_ctrl: got %h want 00000000", bus4.dataOut);
      end
      bus4.addr = '0;
      for (int c = 0; c < 12; c++) begin
         tick();
         n_cmp++;
         if ({gate4, led4} !== 12'h000) begin
            n_err++; $display("FAIL rstmid_idle cyc %0d: gate=%b led=%h, want 0", c, gate4, led4);
         end
      end
   endtask

   task automatic test_readback();
      write8(Base, 32'hDEAD_BEEF);
      bus8.addr = Base; #1;
      n_cmp++;
      if (bus8.dataOut !== 32'hDEAD_BEEF || bus8.hit !== 1'b1) begin
         n_err++; $display("FAIL rd_digit: data=%h hit=%b, want DEADBEEF/1", bus8.dataOut, bus8.hit);
      end
      bus8.addr = Base + 32'h8; #1;
      n_cmp++;
      if (bus8.dataOut !== 32'h0 || bus8.hit !== 1'b0) begin
         n_err++; $display("FAIL rd_miss: data=%h hit=%b, want 00000000/0", bus8.dataOut, bus8.hit);
      end
      write8(Base + 32'h4, 32'hFFFF_FFFF);
      bus8.addr = Base + 32'h4; #1;
      n_cmp++;
      if (bus8.dataOut !== 32'h80FF_00FF || bus8.hit !== 1'b1) begin
         n_err++; $display("FAIL rd_ctrl: data=%h hit=%b, want 80FF00FF/1", bus8.dataOut, bus8.hit);
      end
      bus8.addr = '0;
   endtask

   initial begin
      rst = 1'b0;
      bus4.addr = '0; bus4.dataIn = '0; bus4.wrEnable = 1'b0;
      bus8.addr = '0; bus8.dataIn = '0; bus8.wrEnable = 1'b0;
      #1;
      test_reset();
      test_scan_order();
      test_masks();
      test_ctrl_rewrite();
      test_disable();
      test_reset_mid();
      test_readback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
